posedge_3bit_up_counter: RTL and testbench
==========================================

POSEDGE_3BIT_UP_COUNTER -- requirements
Module: posedge_3bit_up_counter

Interface
REQ-001 The block SHALL have one clock, CLK, and its reset SHALL be asynchronous and active-low, named not_RST.
REQ-002 CLK  input  1  counter clock; all synchronous state changes on the rising edge.
REQ-003 not_RST  input  1  asynchronous active-low reset.
REQ-004 not_PRE  input  1  asynchronous active-low preset of the count.
REQ-005 EN  input  1  count enable, sampled at the CLK rising edge.
REQ-006 LOAD  input  1  synchronous parallel load strobe.
REQ-007 D  input  3  parallel load value; D[0] is the LSB.
REQ-008 MAX  input  3  terminal count; the count wraps to 0 after reaching MAX.
REQ-009 CLR_OVF  input  1  synchronous clear of the sticky overflow flag.
REQ-010 Q0, Q1, Q2  output  1 each  count bits; Q0 is the LSB; all registered.
REQ-011 TC  output  1  terminal-count indication; combinational.
REQ-012 OVF  output  1  sticky wrap flag; registered.

Function
REQ-013 Count Q = {Q2,Q1,Q0}, unsigned 3-bit.
REQ-014 Priority at CLK rising edge: LOAD, then EN, then hold.
REQ-015 LOAD=1: Q <= D on the same edge, regardless of EN or MAX.
- No wrap occurs on a load.
- OVF is not set by a load.
REQ-016 LOAD=0, EN=1, Q < MAX: Q <= Q+1.
REQ-017 LOAD=0, EN=1, Q >= MAX: Q <= 0 (wrap) and OVF <= 1.
- This includes Q > MAX after a load or preset.
- This includes MAX=7: 7 -> 0.
REQ-018 MAX=0 with EN=1: Q stays 0 and every enabled edge is a wrap.
REQ-019 LOAD=0, EN=0: Q holds.
REQ-020 TC = EN & ~LOAD & (Q >= MAX); it is high exactly in the cycle whose next edge wraps.
REQ-021 MAX changes take effect immediately on TC and at the next edge; there is no internal MAX register.
REQ-022 OVF update at each edge:
- wrap sets OVF;
- CLR_OVF=1 with no wrap clears OVF;
- otherwise OVF holds.
REQ-023 Wrap and CLR_OVF on the same edge: OVF = 1 (set wins).
REQ-024 Latency: Q and OVF change one edge after the sampled inputs; TC has zero latency.

Reset
REQ-025 not_RST=0 forces Q=000 and OVF=0 immediately, independent of CLK.
REQ-026 not_PRE=0 (with not_RST=1) forces Q=111 immediately; OVF is unaffected.
REQ-027 not_RST=0 and not_PRE=0 together: reset wins, Q=000.
REQ-028 While not_RST or not_PRE is asserted, clock edges SHALL have no effect on Q; OVF holds under preset only.
REQ-029 Release of not_RST/not_PRE between edges: counting resumes from 000/111 at the first rising edge after release.
REQ-030 Assertion of not_RST mid-count (between edges) clears Q and OVF within the same cycle; no partial update.

Verification
REQ-031 Free count: not_RST 0->1, MAX=7, EN=1, 10 edges -> Q = 1,2,3,4,5,6,7,0,1,2; OVF=1 from the 8th edge; TC=1 while Q=7.
REQ-032 Modulus: MAX=4, EN=1 from Q=0 -> Q = 1,2,3,4,0,1; TC=1 only while Q=4.
REQ-033 Load/enable priority: Q=2, LOAD=1, EN=1, D=6, MAX=3 -> Q=6, TC=0 that cycle; next edge with EN=1 -> Q=0, OVF=1 (Q>MAX wraps).
REQ-034 Async preset/reset:
- not_PRE=0 mid-cycle -> Q=111 before the next edge, OVF unchanged;
- both low -> Q=000;
- release not_PRE then 1 edge with EN=1, MAX=7 -> Q=000, OVF=1.
REQ-035 Sticky flag: OVF=1, CLR_OVF=1 with no wrap -> OVF=0; CLR_OVF=1 coinciding with wrap (Q=MAX=2, EN=1) -> OVF=1, Q=0.
REQ-036 Hold and MAX=0: EN=0 for 3 edges -> Q unchanged; MAX=0, EN=1 -> Q=0 every edge, TC=1, OVF=1.

Source files
------------

// File: rtl/posedge_3bit_up_counter.sv
// ---------------------------------------------------------------------------
// posedge_3bit_up_counter
//
// 3-bit loadable up counter with a programmable terminal count, asynchronous
// reset and preset, and a sticky overflow (wrap) flag.
//
// Ports:
//   CLK      in   counter clock, rising edge active
//   not_RST  in   asynchronous active-low reset (Q=000, OVF=0)
//   not_PRE  in   asynchronous active-low preset (Q=111, OVF untouched)
//   EN       in   count enable, sampled at the rising edge
//   LOAD     in   synchronous parallel load strobe (beats EN)
//   D[2:0]   in   parallel load value
//   MAX[2:0] in   terminal count; the count wraps to 0 after reaching MAX
//   CLR_OVF  in   synchronous clear of the sticky overflow flag
//   Q0..Q2   out  registered count bits, Q0 is the LSB
//   TC       out  combinational: high in the cycle whose next edge wraps
//   OVF      out  registered sticky wrap flag
// ---------------------------------------------------------------------------
module posedge_3bit_up_counter (
    input  logic       CLK,
    input  logic       not_RST,
    input  logic       not_PRE,
    input  logic       EN,
    input  logic       LOAD,
    input  logic [2:0] D,
    input  logic [2:0] MAX,
    input  logic       CLR_OVF,
    output logic       Q0,
    output logic       Q1,
    output logic       Q2,
    output logic       TC,
    output logic       OVF
);

    localparam int DATA_W = 3;

    logic [DATA_W-1:0] count_p0;
    logic              ovf_p0;
    logic              wrap;

    // Next count for an enabled, non-loading edge. A count already at or
    // above the terminal value (possible after a load or preset) wraps too.
    function automatic logic [DATA_W-1:0] next_count(
        input logic [DATA_W-1:0] cur,
        input logic [DATA_W-1:0] lim
    );
        if (cur >= lim)
            next_count = '0;
        else
            next_count = DATA_W'(cur + 1'b1);
    endfunction

    // MAX is used live, so a change shows on TC at once and at the next edge.
    assign wrap = EN & ~LOAD & (count_p0 >= MAX);
    assign TC   = wrap;

    // ---- stage p0: count register (reset beats preset) ----
    always_ff @(posedge CLK or negedge not_RST or negedge not_PRE) begin
        if (!not_RST) begin
            count_p0 <= '0;
        end else if (!not_PRE) begin
            count_p0 <= '1;
        end else if (LOAD) begin
            count_p0 <= D;
        end else if (EN) begin
            count_p0 <= next_count(count_p0, MAX);
        end
    end

    // ---- stage p0: sticky overflow flag ----
    // Preset leaves the flag alone, so it is only checked at clock edges.
    // A wrap on the same edge as CLR_OVF keeps the flag set.
    always_ff @(posedge CLK or negedge not_RST) begin
        if (!not_RST) begin
            ovf_p0 <= 1'b0;
        end else if (not_PRE) begin
            ovf_p0 <= wrap | (ovf_p0 & ~CLR_OVF);
        end
    end

    assign {Q2, Q1, Q0} = count_p0;
    assign OVF          = ovf_p0;

endmodule

// File: tb/tb_posedge_3bit_up_counter.sv
// ---------------------------------------------------------------------------
// tb_posedge_3bit_up_counter
//
// Self-checking bench: reset checks, free count, a vector table for modulus,
// load priority, sticky flag, hold and MAX=0, hand-written async sequences,
// then randomized stimulus against a plain-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_posedge_3bit_up_counter;

    logic       CLK = 1'b0;
    logic       not_RST, not_PRE, EN, LOAD, CLR_OVF;
    logic [2:0] D, MAX;
    logic       Q0, Q1, Q2, TC, OVF;

    int total = 0;
    int bad   = 0;

    // reference model state
    int mq;
    int movf;

    typedef struct {
        logic       load;
        logic       en;
        logic       clr;
        logic [2:0] d;
        logic [2:0] max;
        logic       tc;
        logic [2:0] q;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    posedge_3bit_up_counter dut (
        .CLK     (CLK),
        .not_RST (not_RST),
        .not_PRE (not_PRE),
        .EN      (EN),
        .LOAD    (LOAD),
        .D       (D),
        .MAX     (MAX),
        .CLR_OVF (CLR_OVF),
        .Q0      (Q0),
        .Q1      (Q1),
        .Q2      (Q2),
        .TC      (TC),
        .OVF     (OVF)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] qv();
        return {Q2, Q1, Q0};
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic load, input logic en, input logic clr,
                                input int d, input int max,
                                input logic tc, input int q, input logic ovf);
        vec_t v;
        v.load = load; v.en = en; v.clr = clr;
        v.d = 3'(d); v.max = 3'(max);
        v.tc = tc; v.q = 3'(q); v.ovf = ovf;
        return v;
    endfunction

    // Asynchronous effect of reset/preset levels on the model.
    task automatic model_async();
        if (!not_RST) begin
            mq = 0; movf = 0;
        end else if (!not_PRE) begin
            mq = 7;
        end
    endtask

    // One rising edge of the model, straight from the counting rules.
    task automatic model_edge();
        bit w;
        w = 0;
        if (!not_RST) begin
            mq = 0; movf = 0;
        end else if (!not_PRE) begin
            mq = 7;
        end else begin
            if (LOAD) begin
                mq = D;
            end else if (EN) begin
                if (mq >= MAX) begin
                    mq = 0; w = 1;
                end else begin
                    mq = mq + 1;
                end
            end
            if (w) movf = 1;
            else if (CLR_OVF) movf = 0;
        end
    endtask

    initial begin
        not_RST = 1'b1; not_PRE = 1'b1;
        EN = 1'b0; LOAD = 1'b0; CLR_OVF = 1'b0; D = 3'd0; MAX = 3'd7;

        // ---- reset state, and clock edges ignored under reset ----
        #1 not_RST = 1'b0;
        #1;
        chk("reset_q", 8'(qv()), 8'd0);
        chk("reset_ovf", 8'(OVF), 8'd0);
        EN = 1'b1; LOAD = 1'b1; D = 3'd5;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_hold_q", 8'(qv()), 8'd0);
        LOAD = 1'b0;
        @(negedge CLK);
        not_RST = 1'b1;

        // ---- free count, MAX=7 ----
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("free_tc", 8'(TC), 8'((i % 8) == 7));
            @(posedge CLK);
            #1;
            chk("free_q", 8'(qv()), 8'((i + 1) % 8));
            chk("free_ovf", 8'(OVF), 8'(i >= 7));
            @(negedge CLK);
        end

        // ---- reset asserted mid-count clears Q and OVF at once ----
        #2 not_RST = 1'b0;
        #1;
        chk("midreset_q", 8'(qv()), 8'd0);
        chk("midreset_ovf", 8'(OVF), 8'd0);
        not_RST = 1'b1;
        EN = 1'b0;
        @(negedge CLK);

        // ---- vector table, starting from Q=0, OVF=0 ----
        tbl.push_back(mk(0,1,0,0,4, 0,1,0));
        tbl.push_back(mk(0,1,0,0,4, 0,2,0));
        tbl.push_back(mk(0,1,0,0,4, 0,3,0));
        tbl.push_back(mk(0,1,0,0,4, 0,4,0));
        tbl.push_back(mk(0,1,0,0,4, 1,0,1));
        tbl.push_back(mk(0,1,0,0,4, 0,1,1));
        tbl.push_back(mk(0,1,0,0,4, 0,2,1));
        tbl.push_back(mk(0,0,1,0,4, 0,2,0));
        tbl.push_back(mk(1,1,0,6,3, 0,6,0));
        tbl.push_back(mk(0,1,0,0,3, 1,0,1));
        tbl.push_back(mk(0,0,1,0,3, 0,0,0));
        tbl.push_back(mk(1,0,0,2,2, 0,2,0));
        tbl.push_back(mk(0,1,1,0,2, 1,0,1));
        tbl.push_back(mk(0,1,0,0,7, 0,1,1));
        tbl.push_back(mk(0,0,0,0,7, 0,1,1));
        tbl.push_back(mk(0,0,0,0,7, 0,1,1));
        tbl.push_back(mk(0,0,0,0,7, 0,1,1));
        tbl.push_back(mk(0,1,0,0,0, 1,0,1));
        tbl.push_back(mk(0,1,0,0,0, 1,0,1));
        tbl.push_back(mk(0,1,0,0,0, 1,0,1));
        foreach (tbl[i]) begin
            LOAD = tbl[i].load; EN = tbl[i].en; CLR_OVF = tbl[i].clr;
            D = tbl[i].d; MAX = tbl[i].max;
            #1;
            chk($sformatf("tbl%0d_tc", i), 8'(TC), 8'(tbl[i].tc));
            @(posedge CLK);
            #1;
            chk($sformatf("tbl%0d_q", i), 8'(qv()), 8'(tbl[i].q));
            chk($sformatf("tbl%0d_ovf", i), 8'(OVF), 8'(tbl[i].ovf));
            @(negedge CLK);
        end

        // ---- async preset / reset sequence (state now Q=0, OVF=1) ----
        LOAD = 1'b0; EN = 1'b1; MAX = 3'd3; CLR_OVF = 1'b0;
        @(posedge CLK);
        #1;
        chk("pre_setup_q", 8'(qv()), 8'd1);
        @(negedge CLK);
        #2 not_PRE = 1'b0;
        #1;
        chk("preset_q", 8'(qv()), 8'd7);
        chk("preset_ovf", 8'(OVF), 8'd1);
        CLR_OVF = 1'b1;
        @(posedge CLK);
        #1;
        chk("preset_hold_q", 8'(qv()), 8'd7);
        chk("preset_hold_ovf", 8'(OVF), 8'd1);
        #2 not_RST = 1'b0;
        #1;
        chk("both_low_q", 8'(qv()), 8'd0);
        chk("both_low_ovf", 8'(OVF), 8'd0);
        @(negedge CLK);
        not_RST = 1'b1; CLR_OVF = 1'b0;
        @(posedge CLK);
        #1;
        chk("pre_only_q", 8'(qv()), 8'd7);
        @(negedge CLK);
        not_PRE = 1'b1; EN = 1'b1; MAX = 3'd7;
        @(posedge CLK);
        #1;
        chk("pre_release_q", 8'(qv()), 8'd0);
        chk("pre_release_ovf", 8'(OVF), 8'd1);
        @(negedge CLK);

        // ---- randomized stimulus against the reference model ----
        mq = 0; movf = 1;
        for (int n = 0; n < 400; n++) begin
            int mode;
            mode = $urandom_range(0, 15);
            not_RST = (mode != 0);
            not_PRE = (mode != 1);
            LOAD    = ($urandom_range(0, 5) == 0);
            EN      = ($urandom_range(0, 3) != 0);
            CLR_OVF = ($urandom_range(0, 5) == 0);
            D       = 3'($urandom_range(0, 7));
            MAX     = ($urandom_range(0, 2) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            #1;
            model_async();
            chk("rnd_async_q", 8'(qv()), 8'(mq));
            chk("rnd_tc", 8'(TC), 8'(EN && !LOAD && (mq >= int'(MAX))));
            @(posedge CLK);
            #1;
            model_edge();
            chk("rnd_q", 8'(qv()), 8'(mq));
            chk("rnd_ovf", 8'(OVF), 8'(movf));
            @(negedge CLK);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
